// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding-mux
// encodings, the zero register and the packed shadow-stage entry.
package hazard_unit_pkg;

    localparam int REG_W = 5;

    // Order matches the 3:1 EX mux inputs in_1 / in_2 / in_3.
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             uses_rs;
        logic             uses_rt;
        logic [REG_W-1:0] dest;
        logic             reg_write;
        logic             mem_read;
    } stage_t;

    // MEM wins over WB; $0 is hard-wired and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic             uses,
                                           input logic [REG_W-1:0] src,
                                           input stage_t           mem,
                                           input stage_t           wb);
        if (uses && mem.valid && mem.reg_write && mem.dest != REG_ZERO && mem.dest == src)
            return FWD_MEM;
        if (uses && wb.valid && wb.reg_write && wb.dest != REG_ZERO && wb.dest == src)
            return FWD_WB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_div_tracker.sv
// Busy tracker for the multi-cycle divider: loads the latency when a div
// enters EX, then counts down and saturates at zero.
module hazard_div_tracker #(
    parameter int DIV_LATENCY = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic busy_o
);

    localparam int                CNT_W    = $clog2(DIV_LATENCY + 1);
    localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(DIV_LATENCY);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (start_i)
            cnt_d = LOAD_VAL;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage core: shadow EX/MEM/WB scoreboard,
// EX forwarding selects, load-use / divider stalls and branch flushes.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_W,
    parameter int DIV_LATENCY = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_is_div,
    input  logic                  id_reads_hilo,
    input  logic                  ex_branch_taken,
    output logic                  stall,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    stage_t ex_q, mem_q, wb_q;
    stage_t ex_d;
    logic   accept;
    logic   load_use;
    logic   div_busy;
    logic   div_stall;

    assign load_use = id_valid && ex_q.valid && ex_q.mem_read && ex_q.dest != REG_ZERO &&
                      ((id_uses_rs && ex_q.dest == id_rs) || (id_uses_rt && ex_q.dest == id_rt));
    assign div_stall = div_busy && id_valid && (id_reads_hilo || id_is_div);

    // A taken branch squashes ID anyway, so it overrides any stall.
    assign stall    = (load_use || div_stall) && !ex_branch_taken;
    assign flush_id = ex_branch_taken && !rst;
    assign flush_ex = ex_branch_taken && !rst;
    assign accept   = id_valid && !stall && !ex_branch_taken;

    // Bubbles are fully zeroed so a squashed entry can never request a forward.
    always_comb begin
        ex_d = '0;
        if (accept) begin
            ex_d.valid     = 1'b1;
            ex_d.rs        = id_rs;
            ex_d.rt        = id_rt;
            ex_d.uses_rs   = id_uses_rs;
            ex_d.uses_rt   = id_uses_rt;
            ex_d.dest      = id_dest;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    assign fwd_a = fwd_sel(ex_q.uses_rs, ex_q.rs, mem_q, wb_q);
    assign fwd_b = fwd_sel(ex_q.uses_rt, ex_q.rt, mem_q, wb_q);

    hazard_div_tracker #(
        .DIV_LATENCY (DIV_LATENCY)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept && id_is_div),
        .busy_o  (div_busy)
    );

    // Source fields of MEM/WB are kept for visibility only.
    logic shadow_unused;
    assign shadow_unused = ^{mem_q, wb_q};

    // Load-use stalls must make a forward out of a load in MEM impossible.
    a_no_mem_load_fwd : assert property (@(posedge clk) disable iff (rst)
        !((fwd_a == FWD_MEM || fwd_b == FWD_MEM) && mem_q.mem_read));

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed hazard scenarios plus random
// instruction streams, checked against an instruction-level pipeline model.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0, id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0, id_is_div = 1'b0, id_reads_hilo = 1'b0;
    logic       ex_branch_taken = 1'b0;
    logic       stall, flush_id, flush_ex;
    logic [1:0] fwd_a, fwd_b;

    hazard_unit #(.REG_ADDR_W(5), .DIV_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_is_div(id_is_div),
        .id_reads_hilo(id_reads_hilo), .ex_branch_taken(ex_branch_taken),
        .stall(stall), .flush_id(flush_id), .flush_ex(flush_ex), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v;
        bit [4:0] rs, rt, dest;
        bit       urs, urt, rw, mr, div, hilo;
    } instr_t;

    typedef struct {
        bit       stall, fid, fex;
        bit [1:0] fa, fb;
    } exp_t;

    // Model: which instruction occupies each later stage, plus divider timing.
    instr_t m_ex, m_mem, m_wb, cur_id;
    bit     cur_br, cur_stall;
    int     edge_n, div_edge;
    bit     div_seen;
    exp_t   sb[$];
    int     checks = 0, failures = 0;
    int     cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic instr_t nop_i();
        instr_t t = '{default: 0};
        return t;
    endfunction

    function automatic instr_t alu_i(int d, int s, int t);
        instr_t x = '{default: 0};
        x.v = 1; x.rs = 5'(s); x.rt = 5'(t); x.dest = 5'(d);
        x.urs = 1; x.urt = 1; x.rw = 1;
        return x;
    endfunction

    function automatic instr_t load_i(int d, int base);
        instr_t x = '{default: 0};
        x.v = 1; x.rs = 5'(base); x.rt = 5'(d); x.dest = 5'(d);
        x.urs = 1; x.rw = 1; x.mr = 1;
        return x;
    endfunction

    function automatic instr_t div_i(int s, int t);
        instr_t x = '{default: 0};
        x.v = 1; x.rs = 5'(s); x.rt = 5'(t); x.urs = 1; x.urt = 1; x.div = 1;
        return x;
    endfunction

    function automatic instr_t mflo_i(int d);
        instr_t x = '{default: 0};
        x.v = 1; x.dest = 5'(d); x.rw = 1; x.hilo = 1;
        return x;
    endfunction

    function automatic instr_t rand_instr();
        instr_t x;
        int k = $urandom_range(99);
        int d = $urandom_range(7), s = $urandom_range(7), t = $urandom_range(7);
        if (k < 20)      x = load_i(d, s);
        else if (k < 26) x = div_i(s, t);
        else if (k < 34) x = mflo_i(d);
        else begin
            x = alu_i(d, s, t);
            x.urs = 1'($urandom_range(1));
            x.urt = 1'($urandom_range(1));
        end
        x.v = ($urandom_range(99) < 85);
        return x;
    endfunction

    function automatic void model_reset();
        m_ex = nop_i(); m_mem = nop_i(); m_wb = nop_i();
        edge_n = 0; div_edge = 0; div_seen = 0;
    endfunction

    // Producer lookup for the consumer currently in EX.
    function automatic bit [1:0] model_fwd(bit [4:0] src, bit uses);
        if (!m_ex.v || !uses || src == 0) return 2'd0;
        if (m_mem.v && m_mem.rw && m_mem.dest == src) return 2'd2;
        if (m_wb.v && m_wb.rw && m_wb.dest == src) return 2'd1;
        return 2'd0;
    endfunction

    function automatic exp_t model_eval();
        exp_t e = '{default: 0};
        bit lu, busy;
        if (rst) return e;
        lu = cur_id.v && m_ex.v && m_ex.mr && m_ex.dest != 0 &&
             ((cur_id.urs && m_ex.dest == cur_id.rs) || (cur_id.urt && m_ex.dest == cur_id.rt));
        busy = div_seen && (edge_n - div_edge) < LAT;
        e.stall = (lu || (busy && cur_id.v && (cur_id.hilo || cur_id.div))) && !cur_br;
        e.fid = cur_br;
        e.fex = cur_br;
        e.fa = model_fwd(m_ex.rs, m_ex.urs);
        e.fb = model_fwd(m_ex.rt, m_ex.urt);
        return e;
    endfunction

    function automatic void model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        m_wb = m_mem;
        m_mem = m_ex;
        edge_n++;
        if (cur_id.v && !cur_stall && !cur_br) begin
            m_ex = cur_id;
            if (cur_id.div) begin
                div_seen = 1;
                div_edge = edge_n;
            end
        end else begin
            m_ex = nop_i();
        end
    endfunction

    task automatic drive_id(input instr_t x, input bit br);
        id_valid = x.v; id_rs = x.rs; id_rt = x.rt; id_dest = x.dest;
        id_uses_rs = x.urs; id_uses_rt = x.urt; id_reg_write = x.rw;
        id_mem_read = x.mr; id_is_div = x.div; id_reads_hilo = x.hilo;
        ex_branch_taken = br;
    endtask

    // One cycle: advance the model on the edge, present ID, queue the expectation.
    task automatic issue(input instr_t x, input bit br, input bit r);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        rst = r;
        if (r) model_reset();
        drive_id(x, br);
        cur_id = x;
        cur_br = br;
        e = model_eval();
        cur_stall = e.stall;
        sb.push_back(e);
    endtask

    // Mid-cycle asynchronous reset: replaces this cycle's pending expectation.
    task automatic assert_rst_now();
        exp_t e;
        #1;
        rst = 1'b1;
        model_reset();
        void'(sb.pop_back());
        e = model_eval();
        cur_stall = e.stall;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("stall@%0d", cyc), int'(stall), int'(e.stall));
                check($sformatf("flush_id@%0d", cyc), int'(flush_id), int'(e.fid));
                check($sformatf("flush_ex@%0d", cyc), int'(flush_ex), int'(e.fex));
                check($sformatf("fwd_a@%0d", cyc), int'(fwd_a), int'(e.fa));
                check($sformatf("fwd_b@%0d", cyc), int'(fwd_b), int'(e.fb));
            end
        end
    end

    initial begin : driver
        instr_t n;
        bit br, r;
        model_reset();
        cur_id = nop_i(); cur_br = 0; cur_stall = 0;

        // Reset state, with a branch and a hazard-looking ID present.
        drive_id(alu_i(3, 3, 3), 1'b1);
        #3;
        check("rst_stall", int'(stall), 0);
        check("rst_flush_id", int'(flush_id), 0);
        check("rst_flush_ex", int'(flush_ex), 0);
        check("rst_fwd_a", int'(fwd_a), 0);
        check("rst_fwd_b", int'(fwd_b), 0);

        // Test 1: MEM forward, then WB-only forward.
        issue(alu_i(3, 1, 2), 0, 0);
        issue(alu_i(6, 3, 4), 0, 0);
        issue(nop_i(), 0, 0);
        #1;
        check("t1_mem_fwd_a", int'(fwd_a), 2);
        check("t1_mem_fwd_b", int'(fwd_b), 0);
        check("t1_mem_stall", int'(stall), 0);
        issue(alu_i(3, 1, 2), 0, 0);
        issue(nop_i(), 0, 0);
        issue(alu_i(6, 3, 4), 0, 0);
        issue(nop_i(), 0, 0);
        #1;
        check("t1_wb_fwd_a", int'(fwd_a), 1);

        // Test 2: MEM priority over WB; $0 never forwarded.
        issue(alu_i(3, 1, 2), 0, 0);
        issue(alu_i(3, 1, 2), 0, 0);
        issue(alu_i(6, 3, 4), 0, 0);
        issue(nop_i(), 0, 0);
        #1;
        check("t2_prio_fwd_a", int'(fwd_a), 2);
        issue(alu_i(0, 1, 2), 0, 0);
        issue(alu_i(6, 0, 4), 0, 0);
        issue(nop_i(), 0, 0);
        #1;
        check("t2_zero_fwd_a", int'(fwd_a), 0);

        // Test 3: load-use on rt, one-cycle stall then WB forward.
        issue(load_i(5, 1), 0, 0);
        issue(alu_i(7, 2, 5), 0, 0);
        #1;
        check("t3_stall_on", int'(stall), 1);
        issue(alu_i(7, 2, 5), 0, 0);
        #1;
        check("t3_stall_off", int'(stall), 0);
        issue(nop_i(), 0, 0);
        #1;
        check("t3_fwd_b", int'(fwd_b), 1);

        // Test 4: mflo behind a div stalls LAT cycles.
        issue(div_i(1, 2), 0, 0);
        for (int i = 0; i < LAT; i++) begin
            issue(mflo_i(8), 0, 0);
            #1;
            check($sformatf("t4_stall_%0d", i), int'(stall), 1);
        end
        issue(mflo_i(8), 0, 0);
        #1;
        check("t4_release", int'(stall), 0);
        issue(nop_i(), 0, 0);

        // Test 5: branch during a load-use hazard.
        issue(load_i(7, 1), 0, 0);
        issue(alu_i(9, 7, 2), 1, 0);
        #1;
        check("t5_flush_id", int'(flush_id), 1);
        check("t5_flush_ex", int'(flush_ex), 1);
        check("t5_stall", int'(stall), 0);
        issue(nop_i(), 0, 0);
        #1;
        check("t5_fwd_a", int'(fwd_a), 0);
        check("t5_fwd_b", int'(fwd_b), 0);

        // Test 6: reset mid-div with a load in EX forwarding from MEM.
        issue(div_i(1, 2), 0, 0);
        issue(alu_i(1, 2, 3), 0, 0);
        issue(load_i(9, 1), 0, 0);
        issue(mflo_i(4), 0, 0);
        #1;
        check("t6_pre_stall", int'(stall), 1);
        check("t6_pre_fwd_a", int'(fwd_a), 2);
        assert_rst_now();
        #1;
        check("t6_rst_stall", int'(stall), 0);
        check("t6_rst_fwd_a", int'(fwd_a), 0);
        check("t6_rst_fwd_b", int'(fwd_b), 0);
        issue(mflo_i(4), 0, 1);
        issue(mflo_i(4), 0, 0);
        #1;
        check("t6_after_stall", int'(stall), 0);

        // Random streams: stalled ID is held, flushed ID becomes a bubble.
        for (int i = 0; i < 800; i++) begin
            if (cur_stall)   n = cur_id;
            else if (cur_br) n = nop_i();
            else             n = rand_instr();
            br = ($urandom_range(99) < 6);
            r  = ($urandom_range(249) == 0);
            issue(n, br, r);
        end
        issue(nop_i(), 0, 0);

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        #1;
        check("scoreboard_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
